// File: rtl/read_stage_rr_scheduler_pkg.sv
// read_stage_rr_scheduler_pkg: read-request field widths and packed request struct
package read_stage_rr_scheduler_pkg;
  localparam int VS_W = 5;
  localparam int OFF_W = 8;
  localparam int GRP_W = 4;
  localparam int SRC_W = 4;
  localparam int INST_W = 3;
  typedef struct packed {
    logic [VS_W-1:0]   vs;
    logic [OFF_W-1:0]  offset;
    logic [GRP_W-1:0]  group_index;
    logic [SRC_W-1:0]  read_source;
    logic [INST_W-1:0] instruction_index;
  } read_req_t;
endpackage

// File: rtl/read_stage_rr_scheduler_rr_priority_pick.sv
// rr_priority_pick: first eligible index scanning from ptr with wrap-around
module rr_priority_pick #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] grant_o,
  output logic             hit_o
);
  // Scan from the farthest offset down so the closest eligible index wins last
  always_comb begin
    grant_o = '0;
    for (int k = N - 1; k >= 0; k--)
      if (eligible_i[IDX_W'((int'(ptr_i) + k) % N)]) grant_o = IDX_W'((int'(ptr_i) + k) % N);
  end
  assign hit_o = |eligible_i;
endmodule

// File: rtl/read_stage_rr_scheduler.sv
// read_stage_rr_scheduler: round-robin pick of read requests into one registered output slot
module read_stage_rr_scheduler
  import read_stage_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               io_in_valid,
  output logic [NUM_REQ-1:0]               io_in_ready,
  input  logic [NUM_REQ-1:0][VS_W-1:0]     io_in_bits_vs,
  input  logic [NUM_REQ-1:0][OFF_W-1:0]    io_in_bits_offset,
  input  logic [NUM_REQ-1:0][GRP_W-1:0]    io_in_bits_groupIndex,
  input  logic [NUM_REQ-1:0][SRC_W-1:0]    io_in_bits_readSource,
  input  logic [NUM_REQ-1:0][INST_W-1:0]   io_in_bits_instructionIndex,
  input  logic                             io_kill_valid,
  input  logic [INST_W-1:0]                io_kill_instructionIndex,
  output logic                             io_out_valid,
  input  logic                             io_out_ready,
  output logic [VS_W-1:0]                  io_out_bits_vs,
  output logic [OFF_W-1:0]                 io_out_bits_offset,
  output logic [GRP_W-1:0]                 io_out_bits_groupIndex,
  output logic [SRC_W-1:0]                 io_out_bits_readSource,
  output logic [INST_W-1:0]                io_out_bits_instructionIndex,
  output logic [IDX_W-1:0]                 io_out_grantIndex
);
  read_req_t [NUM_REQ-1:0] reqs;
  logic [NUM_REQ-1:0] eligible;
  logic [IDX_W-1:0] grant, grant_q, grant_d, ptr_q, ptr_d;
  logic hit, kill_hit, out_fire, can_load, in_fire, slot_valid_q, slot_valid_d;
  read_req_t slot_q, slot_d;
  genvar i;
  for (i = 0; i < NUM_REQ; i++) begin : g_req
    assign reqs[i] = '{io_in_bits_vs[i], io_in_bits_offset[i], io_in_bits_groupIndex[i],
                       io_in_bits_readSource[i], io_in_bits_instructionIndex[i]};
    assign eligible[i] = io_in_valid[i] &&
                         !(io_kill_valid && io_in_bits_instructionIndex[i] == io_kill_instructionIndex);
  end
  rr_priority_pick #(.N(NUM_REQ)) u_pick (
    .eligible_i(eligible),
    .ptr_i     (ptr_q),
    .grant_o   (grant),
    .hit_o     (hit)
  );
  // A killed slot frees itself, so it can take a new request in the same cycle
  always_comb begin
    kill_hit = io_kill_valid && slot_valid_q && slot_q.instruction_index == io_kill_instructionIndex;
    io_out_valid = slot_valid_q && !kill_hit;
    out_fire = io_out_valid && io_out_ready;
    can_load = !slot_valid_q || out_fire || kill_hit;
    in_fire = can_load && hit && reset;
    io_in_ready = in_fire ? NUM_REQ'(1) << grant : '0;
    slot_valid_d = in_fire || (slot_valid_q && !out_fire && !kill_hit);
    slot_d = in_fire ? reqs[grant] : slot_q;
    grant_d = in_fire ? grant : grant_q;
    ptr_d = in_fire ? (grant == IDX_W'(NUM_REQ - 1) ? '0 : grant + 1'b1) : ptr_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_valid_q <= 1'b0;
      slot_q <= '0;
      grant_q <= '0;
      ptr_q <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_q <= slot_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
    end
  end
  assign io_out_bits_vs = slot_q.vs;
  assign io_out_bits_offset = slot_q.offset;
  assign io_out_bits_groupIndex = slot_q.group_index;
  assign io_out_bits_readSource = slot_q.read_source;
  assign io_out_bits_instructionIndex = slot_q.instruction_index;
  assign io_out_grantIndex = grant_q;
endmodule

// File: tb/tb_read_stage_rr_scheduler.sv
// tb_read_stage_rr_scheduler: directed and random checks against a request-level scheduler model
module tb_read_stage_rr_scheduler;
  import read_stage_rr_scheduler_pkg::*;
  localparam int N = 4;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] io_in_valid, io_in_ready;
  logic [N-1:0][4:0] io_in_bits_vs;
  logic [N-1:0][7:0] io_in_bits_offset;
  logic [N-1:0][3:0] io_in_bits_groupIndex, io_in_bits_readSource;
  logic [N-1:0][2:0] io_in_bits_instructionIndex;
  logic io_kill_valid, io_out_valid, io_out_ready;
  logic [2:0] io_kill_instructionIndex, io_out_bits_instructionIndex;
  logic [4:0] io_out_bits_vs;
  logic [7:0] io_out_bits_offset;
  logic [3:0] io_out_bits_groupIndex, io_out_bits_readSource;
  logic [1:0] io_out_grantIndex;

  read_stage_rr_scheduler #(.NUM_REQ(N)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_bits_vs(io_in_bits_vs), .io_in_bits_offset(io_in_bits_offset),
    .io_in_bits_groupIndex(io_in_bits_groupIndex), .io_in_bits_readSource(io_in_bits_readSource),
    .io_in_bits_instructionIndex(io_in_bits_instructionIndex),
    .io_kill_valid(io_kill_valid), .io_kill_instructionIndex(io_kill_instructionIndex),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_bits_vs(io_out_bits_vs), .io_out_bits_offset(io_out_bits_offset),
    .io_out_bits_groupIndex(io_out_bits_groupIndex), .io_out_bits_readSource(io_out_bits_readSource),
    .io_out_bits_instructionIndex(io_out_bits_instructionIndex),
    .io_out_grantIndex(io_out_grantIndex)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total = 0;
  // Model: one held request, its source requester, and the next requester to favour
  bit m_valid, khit, exp_ov, exp_fire;
  read_req_t m_slot;
  int m_grant, m_ptr, exp_g;
  logic [N-1:0] exp_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic read_req_t req_of(input int i);
    return '{io_in_bits_vs[i], io_in_bits_offset[i], io_in_bits_groupIndex[i],
             io_in_bits_readSource[i], io_in_bits_instructionIndex[i]};
  endfunction

  function automatic bit killed(input int i);
    return io_kill_valid && io_in_bits_instructionIndex[i] == io_kill_instructionIndex;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_slot = '0;
    m_grant = 0;
    m_ptr = 0;
  endtask

  task automatic rnd_fields();
    for (int i = 0; i < N; i++) begin
      io_in_bits_vs[i] = 5'($urandom);
      io_in_bits_offset[i] = 8'($urandom);
      io_in_bits_groupIndex[i] = 4'($urandom);
      io_in_bits_readSource[i] = 4'($urandom);
      io_in_bits_instructionIndex[i] = 3'($urandom);
    end
  endtask

  task automatic eval();
    #1;
    khit = io_kill_valid && m_valid && m_slot.instruction_index == io_kill_instructionIndex;
    exp_ov = m_valid && !khit;
    exp_g = -1;
    for (int k = 0; k < N; k++)
      if (exp_g < 0 && io_in_valid[2'((m_ptr + k) % N)] && !killed((m_ptr + k) % N)) exp_g = (m_ptr + k) % N;
    exp_fire = reset && (!m_valid || (exp_ov && io_out_ready) || khit) && exp_g >= 0;
    exp_ready = exp_fire ? 4'(1 << exp_g) : 4'b0;
    chk("in_ready", 32'(io_in_ready), 32'(exp_ready));
    chk("out_valid", 32'(io_out_valid), 32'(exp_ov));
    chk("out_bits", 32'({io_out_bits_vs, io_out_bits_offset, io_out_bits_groupIndex,
                         io_out_bits_readSource, io_out_bits_instructionIndex}), 32'(m_slot));
    chk("grant_index", 32'(io_out_grantIndex), 32'(m_grant));
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) model_reset();
    else if (exp_fire) begin
      m_valid = 1;
      m_slot = req_of(exp_g);
      m_grant = exp_g;
      m_ptr = (exp_g + 1) % N;
    end else if ((exp_ov && io_out_ready) || khit) m_valid = 0;
    @(negedge clock);
  endtask

  initial begin
    model_reset();
    io_out_ready = 0;
    io_kill_valid = 0;
    io_kill_instructionIndex = 0;
    io_in_valid = '1;
    rnd_fields();
    @(negedge clock);
    eval(); tick();
    eval(); tick();
    reset = 1;
    // Full round-robin rotation with continuous drain
    io_out_ready = 1;
    for (int c = 0; c < 9; c++) begin
      rnd_fields();
      eval();
      if (c > 0) begin
        chk("rr_seq", 32'(io_out_grantIndex), 32'((c - 1) % 4));
        chk("rr_fire", 32'(io_out_valid && io_out_ready), 32'd1);
      end
      tick();
    end
    io_in_valid = '0; eval(); tick();
    io_in_valid = 4'b0010; eval(); tick();
    io_in_valid = '0; eval(); tick();
    // Sparse requesters 1 and 3 starting from ptr 2
    io_in_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      eval();
      chk("pair_grant", 32'(io_in_ready), c == 1 ? 32'b0010 : 32'b1000);
      tick();
    end
    io_in_valid = '0; eval(); tick();
    // Backpressure holds the slot and the pointer
    io_in_valid = 4'b0001;
    io_in_bits_vs[0] = 5'd7;
    eval(); tick();
    io_out_ready = 0;
    io_in_valid = '1;
    for (int c = 0; c < 5; c++) begin
      rnd_fields();
      eval();
      chk("hold_vs", 32'(io_out_bits_vs), 32'd7);
      chk("hold_ready", 32'(io_in_ready), 32'd0);
      tick();
    end
    io_out_ready = 1;
    eval();
    chk("ptr_kept", 32'(io_in_ready), 32'b0010);
    tick();
    io_in_valid = '0; eval(); tick();
    // Kill of the held instruction frees the slot for another instruction
    io_in_valid = 4'b0100;
    io_in_bits_instructionIndex[2] = 3'd5;
    eval(); tick();
    io_out_ready = 0;
    io_kill_valid = 1;
    io_kill_instructionIndex = 3'd5;
    io_in_valid = 4'b0011;
    io_in_bits_instructionIndex[0] = 3'd2;
    io_in_bits_instructionIndex[1] = 3'd5;
    eval();
    chk("kill_out_valid", 32'(io_out_valid), 32'd0);
    chk("kill_ready", 32'(io_in_ready), 32'b0001);
    tick();
    io_kill_valid = 0;
    io_in_valid = '0;
    eval();
    chk("kill_next_valid", 32'(io_out_valid), 32'd1);
    chk("kill_next_inst", 32'(io_out_bits_instructionIndex), 32'd2);
    chk("kill_next_grant", 32'(io_out_grantIndex), 32'd0);
    tick();
    // Reset while the slot is held under backpressure
    io_in_valid = '1;
    eval();
    #2;
    reset = 0;
    model_reset();
    eval();
    chk("rst_out_valid", 32'(io_out_valid), 32'd0);
    chk("rst_ready", 32'(io_in_ready), 32'd0);
    tick();
    eval(); tick();
    reset = 1;
    io_out_ready = 1;
    eval();
    chk("rst_first_grant", 32'(io_in_ready), 32'b0001);
    tick();
    for (int c = 0; c < 400; c++) begin
      io_in_valid = 4'($urandom);
      rnd_fields();
      io_kill_valid = ($urandom % 4) == 0;
      io_kill_instructionIndex = 3'($urandom);
      io_out_ready = ($urandom % 4) != 0;
      eval();
      tick();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/read_stage_rr_scheduler.md
READ_STAGE_RR_SCHEDULER -- requirements
Module: read_stage_rr_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of read requesters (2..8).
REQ-002 SHALL have localparam IDX_W = clog2(NUM_REQ), width of the grant index.
REQ-003 SHALL have port clock  input  1  the single clock; all state rises on its positive edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port io_in_valid  input  NUM_REQ  per-requester request valid.
REQ-006 SHALL have port io_in_ready  output  NUM_REQ  per-requester accept.
REQ-007 SHALL have port io_in_bits_vs  input  NUM_REQ x 5  source vector register.
REQ-008 SHALL have port io_in_bits_offset  input  NUM_REQ x 8  element-group offset.
REQ-009 SHALL have port io_in_bits_groupIndex  input  NUM_REQ x 4  group index.
REQ-010 SHALL have port io_in_bits_readSource  input  NUM_REQ x 4  read source tag.
REQ-011 SHALL have port io_in_bits_instructionIndex  input  NUM_REQ x 3  owning instruction.
REQ-012 SHALL have port io_kill_valid  input  1  instruction kill strobe.
REQ-013 SHALL have port io_kill_instructionIndex  input  3  instruction being killed.
REQ-014 SHALL have port io_out_valid  output  1  registered read request valid.
REQ-015 SHALL have port io_out_ready  input  1  VRF read port accept.
REQ-016 SHALL have ports io_out_bits_vs/offset/groupIndex/readSource/instructionIndex  output  5/8/4/4/3  registered request fields.
REQ-017 SHALL have port io_out_grantIndex  output  IDX_W  requester that produced the held entry.

Function
REQ-018 SHALL hold one output slot (slotValid + fields + grantIndex); io_out_valid = slotValid AND NOT killHit.
REQ-019 SHALL define killHit = io_kill_valid AND slotValid AND slot instructionIndex == io_kill_instructionIndex.
REQ-020 SHALL define eligible[i] = io_in_valid[i] AND NOT (io_kill_valid AND io_in_bits_instructionIndex[i] == io_kill_instructionIndex).
REQ-021 SHALL define canLoad = NOT slotValid OR (io_out_valid AND io_out_ready) OR killHit.
REQ-022 SHALL pick grant g as the first eligible index scanning ptr, ptr+1, ... wrapping mod NUM_REQ; none if no eligible input.
REQ-023 SHALL drive io_in_ready[i] = canLoad AND eligible[i] AND (i == g); at most one bit high per cycle.
REQ-024 SHALL on an input fire load the slot with requester g's fields and set grantIndex = g; latency input fire to io_out_valid = 1 cycle.
REQ-025 SHALL on an input fire set ptr <= (g+1) mod NUM_REQ; ptr SHALL be unchanged in any cycle without an input fire.
REQ-026 SHALL clear slotValid when the slot drains (out fire) or on killHit, unless it reloads in the same cycle.
REQ-027 SHALL sustain one request per cycle under continuous io_out_ready (drain and load in the same cycle).
REQ-028 SHALL hold slot fields stable while io_out_valid AND NOT io_out_ready.
REQ-029 SHALL never drop or duplicate a non-killed accepted request.

Reset
REQ-030 SHALL on reset assertion asynchronously set slotValid=0, ptr=0, all slot fields and grantIndex=0; io_out_valid and io_in_ready SHALL be 0 while reset is low.
REQ-031 SHALL discard an in-flight slot entry when reset asserts mid-operation; ptr restarts at 0.

Structure
REQ-032 SHALL place the read-request field widths (5/8/4/4/3) and a packed read-request struct in the shared read-stage package.
REQ-033 SHALL implement the wrap-around priority pick as sub-module rr_priority_pick (inputs eligible, ptr; outputs grant index and hit).

Verification
REQ-034 SHALL cover: NUM_REQ=4, all valid, io_out_ready=1 for 8 cycles -> grantIndex sequence 0,1,2,3,0,1,2,3, one io_out fire per cycle.
REQ-035 SHALL cover: requesters 1 and 3 valid, ptr=2 -> grant 3 first, then 1, then 3.
REQ-036 SHALL cover: slot holds vs=7 with io_out_ready=0 for 5 cycles -> io_out_bits constant, all io_in_ready=0, ptr unchanged.
REQ-037 SHALL cover: slot instructionIndex=5, kill with index 5 -> io_out_valid=0 that cycle; requester with instructionIndex=2 is loaded and appears next cycle; requester with instructionIndex=5 is not granted.
REQ-038 SHALL cover: reset asserted while slotValid=1 and io_out_ready=0 -> io_out_valid=0 immediately; after release, first grant is requester 0.
